// File: rtl/mips32_prog_loader.sv
// Program loader for the pipe_MIPS32 core: streams words through a small FIFO into the
// core's unified memory from base_addr, then releases the core and reports a checksum.
module mips32_prog_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 4
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              core_run,
  output logic [31:0]       checksum,
  output logic              start_err
);

  localparam int DATA_W = 32;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     accepted_q, accepted_d;
  logic [ADDR_W:0]     written_q, written_d;
  logic [DATA_W-1:0]   fifo_mem_q [DEPTH];
  logic [DATA_W-1:0]   fifo_mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   checksum_q, checksum_d;
  logic                core_run_q, core_run_d;
  logic                start_err_q, start_err_d;

  logic                fifo_full;
  logic                ready_c;
  logic                push;
  logic                pop;

  function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [ADDR_W:0]   offs);
    return base + offs[ADDR_W-1:0];
  endfunction

  // Ready depends only on registered state, so a same-cycle pop never raises it.
  assign fifo_full = (count_q == CNT_W'(DEPTH));
  assign ready_c   = (state_q == ST_LOAD) && !fifo_full && (accepted_q < len_q);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    accepted_d  = accepted_q;
    written_d   = written_q;
    fifo_mem_d  = fifo_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    checksum_d  = checksum_q;
    core_run_d  = core_run_q;
    start_err_d = start_err_q;
    push        = 1'b0;
    pop         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d      = base_addr;
          len_d       = len;
          accepted_d  = '0;
          written_d   = '0;
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
          count_d     = '0;
          checksum_d  = '0;
          start_err_d = 1'b0;
          if (len == '0) begin
            state_d    = ST_DONE;
            core_run_d = 1'b1;
          end else begin
            state_d    = ST_LOAD;
            core_run_d = 1'b0;
          end
        end
      end

      ST_LOAD: begin
        if (start) start_err_d = 1'b1;
        push = s_valid && ready_c;
        pop  = (count_q != '0);
        if (push) begin
          fifo_mem_d[wr_ptr_q] = s_data;
          wr_ptr_d             = wr_ptr_q + 1'b1;
          accepted_d           = accepted_q + 1'b1;
        end
        if (pop) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = wrap_addr(base_q, written_q);
          mem_wdata_d = fifo_mem_q[rd_ptr_q];
          checksum_d  = checksum_q + fifo_mem_q[rd_ptr_q];
          rd_ptr_d    = rd_ptr_q + 1'b1;
          written_d   = written_q + 1'b1;
          if (written_q + 1'b1 == len_q) begin
            state_d    = ST_DONE;
            core_run_d = 1'b1;
          end
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end

      ST_DONE: begin
        if (start) start_err_d = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO storage holds only data and needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk1) begin
    fifo_mem_q <= fifo_mem_d;
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      accepted_q  <= '0;
      written_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      checksum_q  <= '0;
      core_run_q  <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      accepted_q  <= accepted_d;
      written_q   <= written_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      checksum_q  <= checksum_d;
      core_run_q  <= core_run_d;
      start_err_q <= start_err_d;
    end
  end

  assign s_ready   = ready_c;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q == ST_LOAD);
  assign done      = (state_q == ST_DONE);
  assign core_run  = core_run_q;
  assign checksum  = checksum_q;
  assign start_err = start_err_q;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed bench for mips32_prog_loader: drives loads, logs memory writes and compares
// them with hand-derived address/data/checksum expectations.
module tb_mips32_prog_loader;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] len;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        core_run;
  logic [31:0] checksum;
  logic        start_err;

  always #5 clk1 = ~clk1;

  mips32_prog_loader #(.ADDR_W(10), .DEPTH(4)) dut (
    .clk1      (clk1),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .core_run  (core_run),
    .checksum  (checksum),
    .start_err (start_err)
  );

  logic [31:0] img [16];
  logic [9:0]  waddr [$];
  logic [31:0] wdata [$];
  int          checks = 0;
  int          errors = 0;
  int          done_cyc;
  int          over;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // mode 0: s_valid held high; mode 1: s_valid on even cycles only.
  task automatic do_load(input logic [9:0] base, input int n, input int mode,
                         input bit inj_start, input bit abort);
    int idx;
    bit acc;
    bit fin;
    idx = 0;
    fin = 1'b0;
    over = 0;
    done_cyc = -1;
    waddr.delete();
    wdata.delete();
    @(negedge clk1);
    start = 1'b1;
    base_addr = base;
    len = 11'(n);
    @(negedge clk1);
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("core_run_cleared", {31'd0, core_run}, 32'd0);
    check("start_err_cleared", {31'd0, start_err}, 32'd0);
    check("no_we_after_start", {31'd0, mem_we}, 32'd0);
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      s_valid = (idx < n) && (mode == 0 || (cyc % 2) == 0);
      s_data  = img[idx % 16];
      start   = inj_start && (cyc == 2);
      if (idx >= n && s_ready) over++;
      acc = s_valid && s_ready;
      @(negedge clk1);
      start = 1'b0;
      if (mem_we) begin
        waddr.push_back(mem_addr);
        wdata.push_back(mem_wdata);
      end
      if (acc) idx++;
      if (done) begin
        fin = 1'b1;
        done_cyc = cyc;
      end
      if (abort && waddr.size() == 2) begin
        rst = 1'b1;
        @(negedge clk1);
        rst = 1'b0;
        s_valid = 1'b0;
        return;
      end
    end
    s_valid = 1'b0;
    if (!fin) check("load_timeout", 32'd0, 32'd1);
    @(negedge clk1);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("idle_not_busy", {31'd0, busy}, 32'd0);
    check("core_run_held", {31'd0, core_run}, 32'd1);
    check("no_trailing_we", {31'd0, mem_we}, 32'd0);
  endtask

  task automatic verify(input string tg, input logic [9:0] base, input int n);
    logic [31:0] sum;
    logic [9:0]  a;
    sum = 32'd0;
    check($sformatf("%s_nwr", tg), 32'(waddr.size()), 32'(n));
    for (int i = 0; i < n && i < waddr.size(); i++) begin
      a = base + 10'(i);
      check($sformatf("%s_addr%0d", tg, i), {22'd0, waddr[i]}, {22'd0, a});
      check($sformatf("%s_data%0d", tg, i), wdata[i], img[i]);
      sum = sum + img[i];
    end
    check($sformatf("%s_checksum", tg), checksum, sum);
    check($sformatf("%s_over_accept", tg), 32'(over), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    len = '0;
    s_valid = 1'b0;
    s_data = '0;
    for (int i = 0; i < 16; i++) img[i] = 32'hA5A5_0000 + 32'(i) * 32'h0101_0001;
    repeat (3) @(negedge clk1);
    rst = 1'b0;
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_core_run", {31'd0, core_run}, 32'd0);
    check("rst_start_err", {31'd0, start_err}, 32'd0);
    check("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_checksum", checksum, 32'd0);

    // T1: three instructions back-to-back from address 0
    img[0] = 32'h00432800;
    img[1] = 32'h04433800;
    img[2] = 32'h14434800;
    do_load(10'd0, 3, 0, 1'b0, 1'b0);
    verify("t1", 10'd0, 3);
    check("t1_done_latency", 32'(done_cyc), 32'd3);
    check("t1_checksum_const", checksum, 32'h18C9A800);
    for (int i = 0; i < 16; i++) img[i] = 32'hA5A5_0000 + 32'(i) * 32'h0101_0001;

    // T2: starved stream, one word every other cycle
    do_load(10'd16, 8, 1, 1'b0, 1'b0);
    verify("t2", 10'd16, 8);

    // T3: sustained one word per cycle
    do_load(10'd40, 6, 0, 1'b0, 1'b0);
    verify("t3", 10'd40, 6);
    check("t3_done_latency", 32'(done_cyc), 32'd6);

    // T4: address wrap past the top of memory
    do_load(10'd1022, 4, 0, 1'b0, 1'b0);
    verify("t4", 10'd1022, 4);
    if (waddr.size() == 4) begin
      check("t4_wrap_addr2", {22'd0, waddr[2]}, 32'd0);
      check("t4_wrap_addr3", {22'd0, waddr[3]}, 32'd1);
    end else begin
      check("t4_wrap_count", 32'(waddr.size()), 32'd4);
    end

    // T5: start during LOAD is ignored and flagged; next real start clears it
    do_load(10'd100, 5, 0, 1'b1, 1'b0);
    verify("t5", 10'd100, 5);
    check("t5_start_err", {31'd0, start_err}, 32'd1);
    do_load(10'd200, 2, 1, 1'b0, 1'b0);
    verify("t5b", 10'd200, 2);

    // T6: reset after two writes, then an empty load
    do_load(10'd300, 5, 0, 1'b0, 1'b1);
    check("t6_nwr", 32'(waddr.size()), 32'd2);
    check("t6_we_after_rst", {31'd0, mem_we}, 32'd0);
    check("t6_busy_after_rst", {31'd0, busy}, 32'd0);
    check("t6_core_run_after_rst", {31'd0, core_run}, 32'd0);
    check("t6_ready_after_rst", {31'd0, s_ready}, 32'd0);
    check("t6_checksum_after_rst", checksum, 32'd0);
    @(negedge clk1);
    check("t6_no_late_we", {31'd0, mem_we}, 32'd0);
    start = 1'b1;
    base_addr = 10'd5;
    len = 11'd0;
    @(negedge clk1);
    start = 1'b0;
    check("t6_len0_done", {31'd0, done}, 32'd1);
    check("t6_len0_core_run", {31'd0, core_run}, 32'd1);
    check("t6_len0_checksum", checksum, 32'd0);
    check("t6_len0_busy", {31'd0, busy}, 32'd0);
    check("t6_len0_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk1);
    check("t6_len0_done_pulse", {31'd0, done}, 32'd0);
    check("t6_len0_core_run_held", {31'd0, core_run}, 32'd1);
    check("t6_len0_no_we", {31'd0, mem_we}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
